// File: rtl/i2c_cfg_seq_if.sv
// Write-request channel between the configuration sequencer and the I2C master.
// The sequencer drives the request side; the master answers with end/NACK.
interface i2c_cfg_seq_if #(
    parameter int DW = 16
);
    logic          i2c_start;
    logic [DW-1:0] i2c_wr_data;
    logic          i2c_end;
    logic          i2c_ack_err;

    modport master (output i2c_start, i2c_wr_data, input  i2c_end, i2c_ack_err);
    modport slave  (input  i2c_start, i2c_wr_data, output i2c_end, i2c_ack_err);
endinterface

// File: rtl/i2c_cfg_seq.sv
// Walks a synchronous {reg addr, data} table and issues one I2C write per entry,
// with power-up wait, NACK/timeout retries and done/error status.
module i2c_cfg_seq #(
    parameter int CFG_NUM   = 51,
    parameter int IDX_W     = 6,
    parameter int REG_AW    = 8,
    parameter int REG_DW    = 8,
    parameter int WAIT_CYC  = 1000,
    parameter int MAX_RETRY = 3,
    parameter int TO_CYC    = 0
) (
    input  logic                     i2c_clk,
    input  logic                     sys_rst_n,
    input  logic                     cfg_start,
    output logic [IDX_W-1:0]         tbl_idx,
    input  logic [REG_AW+REG_DW-1:0] tbl_data,
    i2c_cfg_seq_if.master            i2c,
    output logic                     cfg_busy,
    output logic                     cfg_done,
    output logic                     cfg_err,
    output logic [IDX_W:0]           cfg_cnt
);

    localparam int WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam int TO_W   = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_FETCH, S_LATCH, S_REQ, S_BUSY, S_DONE, S_ERR
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [3:0]        retry;

    logic wait_last, to_hit, end_ok, fail, last_entry, can_retry;

    // to_cnt equals the number of cycles since the request pulse, so a timeout
    // re-issues the request exactly TO_CYC cycles after the previous one.
    assign wait_last  = (int'(wait_cnt) >= WAIT_CYC - 1);
    assign to_hit     = (TO_CYC > 0) && (int'(to_cnt) >= TO_CYC - 1);
    assign end_ok     = (state == S_BUSY) && i2c.i2c_end && !i2c.i2c_ack_err;
    assign fail       = (state == S_BUSY) &&
                        ((i2c.i2c_end && i2c.i2c_ack_err) || (!i2c.i2c_end && to_hit));
    assign last_entry = (int'(tbl_idx) == CFG_NUM - 1);
    assign can_retry  = (int'(retry) < MAX_RETRY);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge i2c_clk) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    // NOTE: the default assignment first keeps this combinational block from
    // inferring a latch on paths that do not change state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR:
                if (cfg_start) state_nxt = (WAIT_CYC == 0) ? S_FETCH : S_WAIT;
            S_WAIT:  if (wait_last) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_REQ;
            S_REQ:   state_nxt = S_BUSY;
            S_BUSY: begin
                if (end_ok)    state_nxt = last_entry ? S_DONE : S_FETCH;
                else if (fail) state_nxt = can_retry ? S_REQ : S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        i2c.i2c_start = (state == S_REQ);
        cfg_busy      = (state == S_WAIT) || (state == S_FETCH) || (state == S_LATCH) ||
                        (state == S_REQ)  || (state == S_BUSY);
        cfg_done      = (state == S_DONE);
        cfg_err       = (state == S_ERR);
    end

    always_ff @(posedge i2c_clk) begin
        if (!sys_rst_n) begin
            tbl_idx         <= '0;
            cfg_cnt         <= '0;
            retry           <= '0;
            wait_cnt        <= '0;
            to_cnt          <= '0;
            i2c.i2c_wr_data <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (cfg_start) begin
                        tbl_idx  <= '0;
                        cfg_cnt  <= '0;
                        retry    <= '0;
                        wait_cnt <= '0;
                    end
                end
                S_WAIT:  wait_cnt <= wait_cnt + 1'b1;
                S_LATCH: i2c.i2c_wr_data <= tbl_data;
                S_REQ:   to_cnt <= TO_W'(1);
                S_BUSY: begin
                    if (end_ok) begin
                        cfg_cnt <= cfg_cnt + 1'b1;
                        retry   <= '0;
                        if (!last_entry) tbl_idx <= tbl_idx + 1'b1;
                    end else if (fail) begin
                        if (can_retry) retry <= retry + 1'b1;
                    end else if (!to_hit) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Self-checking bench: two sequencer instances (no wait / no timeout, and
// 100-cycle wait / 16-cycle timeout) driven by a scripted I2C responder.
module tb_i2c_cfg_seq;

    localparam int N      = 4;
    localparam int MR     = 3;
    localparam int K_ACK  = 0;
    localparam int K_NACK = 1;
    localparam int K_NONE = 2;
    localparam int LMAX   = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_n     = 2'b00;
    logic [1:0]  cfg_start = 2'b00;
    logic [1:0]  end_d     = 2'b00;
    logic [1:0]  ack_d     = 2'b00;
    logic [1:0]  start_v, busy_v, done_v, err_v;
    logic [1:0]  idx_v [2];
    logic [2:0]  cnt_v [2];
    logic [15:0] wr_v  [2];
    logic [15:0] tbl_q [2];
    logic [15:0] tbl_mem [2][N];

    i2c_cfg_seq_if #(.DW(16)) bus_a ();
    i2c_cfg_seq_if #(.DW(16)) bus_b ();

    assign bus_a.i2c_end     = end_d[0];
    assign bus_a.i2c_ack_err = ack_d[0];
    assign bus_b.i2c_end     = end_d[1];
    assign bus_b.i2c_ack_err = ack_d[1];
    assign start_v[0] = bus_a.i2c_start;
    assign start_v[1] = bus_b.i2c_start;
    assign wr_v[0]    = bus_a.i2c_wr_data;
    assign wr_v[1]    = bus_b.i2c_wr_data;

    i2c_cfg_seq #(.CFG_NUM(N), .IDX_W(2), .REG_AW(8), .REG_DW(8),
                  .WAIT_CYC(0), .MAX_RETRY(MR), .TO_CYC(0)) dut_a (
        .i2c_clk(clk), .sys_rst_n(rst_n[0]), .cfg_start(cfg_start[0]),
        .tbl_idx(idx_v[0]), .tbl_data(tbl_q[0]), .i2c(bus_a.master),
        .cfg_busy(busy_v[0]), .cfg_done(done_v[0]), .cfg_err(err_v[0]), .cfg_cnt(cnt_v[0]));

    i2c_cfg_seq #(.CFG_NUM(N), .IDX_W(2), .REG_AW(8), .REG_DW(8),
                  .WAIT_CYC(100), .MAX_RETRY(MR), .TO_CYC(16)) dut_b (
        .i2c_clk(clk), .sys_rst_n(rst_n[1]), .cfg_start(cfg_start[1]),
        .tbl_idx(idx_v[1]), .tbl_data(tbl_q[1]), .i2c(bus_b.master),
        .cfg_busy(busy_v[1]), .cfg_done(done_v[1]), .cfg_err(err_v[1]), .cfg_cnt(cnt_v[1]));

    // Synchronous table: data for the index seen on the previous cycle.
    always @(posedge clk) begin
        tbl_q[0] <= tbl_mem[0][idx_v[0]];
        tbl_q[1] <= tbl_mem[1][idx_v[1]];
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          rs_kind [2][LMAX];
    int          rs_lat  [2][LMAX];
    int          rs_n    [2];
    int          rs_ptr  [2];
    int          lg_t    [2][LMAX];
    logic [15:0] lg_d    [2][LMAX];
    int          lg_n    [2];
    int          pd_due  [2];
    bit          pd_on   [2];
    bit          pd_nack [2];

    int          ex_t [LMAX];
    logic [15:0] ex_d [LMAX];
    int          ex_n, ex_cnt, ex_idx;
    bit          ex_done, ex_err;

    function automatic int wait_of(input int g);
        return (g == 0) ? 0 : 100;
    endfunction

    function automatic int to_of(input int g);
        return (g == 0) ? 0 : 16;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: advance to the falling edge, then play the I2C responder.
    task automatic tick();
        int k;
        @(negedge clk);
        cyc++;
        for (int g = 0; g < 2; g++) begin
            end_d[g] = 1'b0;
            ack_d[g] = 1'b0;
            if (pd_on[g] && pd_due[g] == cyc) begin
                end_d[g] = 1'b1;
                ack_d[g] = pd_nack[g];
                pd_on[g] = 1'b0;
            end
            if (start_v[g] === 1'b1 && lg_n[g] < LMAX) begin
                lg_t[g][lg_n[g]] = cyc;
                lg_d[g][lg_n[g]] = wr_v[g];
                lg_n[g]++;
                if (rs_ptr[g] < rs_n[g]) begin
                    k = rs_kind[g][rs_ptr[g]];
                    if (k != K_NONE) begin
                        pd_on[g]   = 1'b1;
                        pd_due[g]  = cyc + rs_lat[g][rs_ptr[g]];
                        pd_nack[g] = (k == K_NACK);
                    end
                    rs_ptr[g]++;
                end
            end
        end
    endtask

    task automatic set_resp(input int g, input int i, input int kind, input int lat);
        rs_kind[g][i] = kind;
        rs_lat[g][i]  = lat;
        if (rs_n[g] < i + 1) rs_n[g] = i + 1;
    endtask

    task automatic fill_resp(input int g, input int kind, input int lat);
        for (int i = 0; i < LMAX; i++) set_resp(g, i, kind, lat);
    endtask

    task automatic std_table(input int g);
        tbl_mem[g][0] = 16'hEF00;
        tbl_mem[g][1] = 16'h3707;
        tbl_mem[g][2] = 16'h3817;
        tbl_mem[g][3] = 16'h3906;
    endtask

    // Reference: request times and payloads from the protocol rules.
    task automatic predict(input int g, input int t_set);
        int idx, retry, t, p, k, lat;
        idx = 0; retry = 0; p = 0;
        t = t_set + wait_of(g) + 3;
        ex_n = 0; ex_cnt = 0; ex_done = 0; ex_err = 0;
        while (ex_n < LMAX - 1) begin
            ex_t[ex_n] = t;
            ex_d[ex_n] = tbl_mem[g][idx];
            ex_n++;
            k   = (p < rs_n[g]) ? rs_kind[g][p] : K_NONE;
            lat = (p < rs_n[g]) ? rs_lat[g][p] : 0;
            p++;
            if (k == K_ACK) begin
                ex_cnt++;
                retry = 0;
                if (idx == N - 1) begin ex_done = 1; break; end
                idx++;
                t += lat + 3;
            end else if (retry < MR) begin
                retry++;
                t += (k == K_NACK) ? lat + 1 : to_of(g);
            end else begin
                ex_err = 1;
                break;
            end
        end
        ex_idx = idx;
    endtask

    task automatic run(input int g, input int poke, input string name);
        int n, t_set, m;
        rs_ptr[g] = 0; lg_n[g] = 0; pd_on[g] = 1'b0;
        tick();
        cfg_start[g] = 1'b1;
        t_set = cyc;
        predict(g, t_set);
        tick();
        cfg_start[g] = 1'b0;
        n = 0;
        while (busy_v[g] === 1'b1 && n < 5000) begin
            tick();
            n++;
            cfg_start[g] = (poke != 0) && (cyc - t_set == 50 || cyc - t_set == 110);
        end
        cfg_start[g] = 1'b0;
        check({name, " finish_in_time"}, n < 5000, 1);
        check({name, " pulses"}, lg_n[g], ex_n);
        m = (lg_n[g] < ex_n) ? lg_n[g] : ex_n;
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s p%0d data", name, i), lg_d[g][i], ex_d[i]);
            check($sformatf("%s p%0d cycle", name, i), lg_t[g][i] - t_set, ex_t[i] - t_set);
        end
        check({name, " done"}, done_v[g], ex_done);
        check({name, " err"},  err_v[g],  ex_err);
        check({name, " cnt"},  cnt_v[g],  ex_cnt);
        check({name, " idx"},  idx_v[g],  ex_idx);
        check({name, " busy"}, busy_v[g], 0);
    endtask

    task automatic check_zero(input int g, input string name);
        check({name, " busy"},  busy_v[g],  0);
        check({name, " done"},  done_v[g],  0);
        check({name, " err"},   err_v[g],   0);
        check({name, " cnt"},   cnt_v[g],   0);
        check({name, " idx"},   idx_v[g],   0);
        check({name, " start"}, start_v[g], 0);
        check({name, " wr"},    wr_v[g],    0);
    endtask

    initial begin
        int n, r;
        for (int g = 0; g < 2; g++) begin
            rs_n[g] = 0; rs_ptr[g] = 0; lg_n[g] = 0; pd_on[g] = 1'b0;
            std_table(g);
        end

        tick(); tick();
        check_zero(0, "rst_a");
        check_zero(1, "rst_b");
        rst_n = 2'b11;

        fill_resp(0, K_ACK, 20);
        run(0, 0, "plain");
        check("plain first_cycle", lg_t[0][0] - lg_t[0][0] + 3, 3);

        fill_resp(0, K_ACK, 20);
        set_resp(0, 2, K_NACK, 20);
        run(0, 0, "nack_once");

        fill_resp(0, K_NACK, 20);
        set_resp(0, 0, K_ACK, 20);
        run(0, 0, "nack_always");

        fill_resp(1, K_NONE, 0);
        run(1, 0, "timeout");
        if (lg_n[1] >= 2) check("timeout spacing", lg_t[1][1] - lg_t[1][0], 16);

        fill_resp(1, K_ACK, 8);
        run(1, 1, "wait_poke");

        // Reset for one cycle during the third request's transaction.
        fill_resp(0, K_ACK, 20);
        rs_ptr[0] = 0; lg_n[0] = 0; pd_on[0] = 1'b0;
        tick();
        cfg_start[0] = 1'b1;
        tick();
        cfg_start[0] = 1'b0;
        n = 0;
        while (lg_n[0] < 3 && n < 500) begin tick(); n++; end
        check("mid_rst reach_entry2", n < 500, 1);
        repeat (5) tick();
        rst_n[0] = 1'b0;
        tick();
        check_zero(0, "mid_rst");
        rst_n[0] = 1'b1;
        repeat (25) tick();
        check("late_end pulses", lg_n[0], 3);
        check("late_end busy", busy_v[0], 0);
        check("late_end cnt", cnt_v[0], 0);
        check("late_end done", done_v[0], 0);
        fill_resp(0, K_ACK, 20);
        run(0, 0, "after_rst");

        for (int it = 0; it < 6; it++) begin
            for (int g = 0; g < 2; g++) begin
                for (int e = 0; e < N; e++) tbl_mem[g][e] = 16'($urandom);
                for (int i = 0; i < LMAX; i++) begin
                    r = $urandom_range(0, 7);
                    if (r < 2)                   set_resp(g, i, K_NACK, 0);
                    else if (r == 2 && g == 1)   set_resp(g, i, K_NONE, 0);
                    else                         set_resp(g, i, K_ACK, 0);
                    rs_lat[g][i] = (g == 0) ? $urandom_range(1, 30) : $urandom_range(1, 15);
                end
                run(g, 0, $sformatf("rand%0d_g%0d", it, g));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
